// File: rtl/reg_file_pkg.sv
// Shared constants and types for the integer register file.
package reg_file_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned REG_ZERO = 0;
  // Link register written by jal.
  localparam int unsigned REG_RA   = 31;

  typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_file_wdec.sv
// Write-address decoder: turns a3/we into a one-hot register write-enable vector.
module reg_file_wdec #(
  parameter int unsigned ADDR_W = reg_file_pkg::ADDR_W,
  localparam int unsigned DEPTH = 32'(1) << ADDR_W
) (
  input  logic              we_i,
  input  logic [ADDR_W-1:0] a3_i,
  output logic [DEPTH-1:0]  wen_c_o
);
  import reg_file_pkg::*;

  // The zero register is hard-wired, so its enable can never fire.
  always_comb begin
    wen_c_o = '0;
    if (we_i) begin
      wen_c_o[a3_i] = 1'b1;
    end
    wen_c_o[REG_ZERO] = 1'b0;
  end

endmodule

// File: rtl/reg_file.sv
// Three-port register file: two combinational reads, one synchronous write,
// register 0 hard-wired to zero, synchronous active-high reset.
module reg_file #(
  parameter int unsigned DATA_W = reg_file_pkg::DATA_W,
  parameter int unsigned ADDR_W = reg_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [ADDR_W-1:0] a3,
  input  logic [DATA_W-1:0] wd3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);
  import reg_file_pkg::*;

  localparam int unsigned DEPTH = 32'(1) << ADDR_W;

  logic [DEPTH-1:0]  wen_c;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  reg_file_wdec #(
    .ADDR_W (ADDR_W)
  ) u_wdec (
    .we_i    (we),
    .a3_i    (a3),
    .wen_c_o (wen_c)
  );

  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wen_c[i]) begin
        regs_d[i] = wd3;
      end
    end
  end

  // Reset wins over any coincident write.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads come straight from the array: no write-through bypass, so a
  // same-cycle write is visible only after the edge.
  assign rd1 = (a1 == ADDR_W'(REG_ZERO)) ? DATA_W'(0) : regs_q[a1];
  assign rd2 = (a2 == ADDR_W'(REG_ZERO)) ? DATA_W'(0) : regs_q[a2];

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
`timescale 1ns/1ps
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [31:0] rd1;
  logic [31:0] rd2;

  int vectors;
  int miscompares;

  reg_file dut (
    .clk (clk),
    .rst (rst),
    .we  (we),
    .a1  (a1),
    .a2  (a2),
    .a3  (a3),
    .wd3 (wd3),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unknown write address while writing is illegal stimulus.
  always @(posedge clk) begin
    assert (!(we === 1'b1 && $isunknown(a3))) else begin
      miscompares++;
      $error("FAIL a3_unknown observed=%b required=known", a3);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    we  = 1'b1;
    a3  = addr;
    wd3 = data;
    @(posedge clk);
    #1;
    we  = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [4:0] addr1, input logic [31:0] exp1,
                    input logic [4:0] addr2, input logic [31:0] exp2);
    a1 = addr1;
    a2 = addr2;
    @(negedge clk);
    check({tag, "_rd1"}, rd1, exp1);
    check({tag, "_rd2"}, rd2, exp2);
  endtask

  initial begin
    logic [31:0] walk;
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1; we = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0;

    // Power-up reset.
    @(posedge clk);
    #1;
    rd("por", 5'd1, 32'h0, 5'd31, 32'h0);
    rst = 1'b0;

    // First edge after reset release must accept a write.
    wr(5'd1, 32'hFFFF_FFFF);
    rd("first_wr", 5'd1, 32'hFFFF_FFFF, 5'd0, 32'h0);

    // Preload everything with ones.
    for (int i = 2; i < 32; i++) wr(5'(i), 32'hFFFF_FFFF);
    rd("preload", 5'd17, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFF);

    // Reset with a coincident write to r31: write dropped, all clear.
    rst = 1'b1;
    wr(5'd31, 32'hCAFE_F00D);
    for (int i = 0; i < 32; i++) rd("rst_all", 5'(i), 32'h0, 5'(31 - i), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rd("post_rst", 5'd31, 32'h0, 5'd8, 32'h0);

    // Basic write/read on both ports.
    wr(5'd8, 32'h1234_5678);
    rd("basic", 5'd8, 32'h1234_5678, 5'd8, 32'h1234_5678);

    // Zero register ignores writes.
    wr(5'd0, 32'hDEAD_BEEF);
    rd("zero", 5'd0, 32'h0, 5'd0, 32'h0);

    // Read-during-write returns the old value until the edge.
    wr(5'd9, 32'h0000_0011);
    a1  = 5'd9;
    we  = 1'b1;
    a3  = 5'd9;
    wd3 = 32'h0000_0022;
    #1;
    check("rdw_before", rd1, 32'h0000_0011);
    @(posedge clk);
    #1;
    we = 1'b0;
    check("rdw_after", rd1, 32'h0000_0022);

    // Write enable low must not disturb the target.
    wr(5'd5, 32'h0000_0005);
    we  = 1'b0;
    a3  = 5'd5;
    wd3 = 32'hAAAA_5555;
    @(posedge clk);
    #1;
    rd("we_gate", 5'd5, 32'h0000_0005, 5'd8, 32'h1234_5678);

    // Walking ones across r1..r31, then read each with its lower neighbour.
    for (int i = 1; i < 32; i++) begin
      walk = 32'h1 << i;
      wr(5'(i), walk);
    end
    for (int i = 1; i < 32; i++) begin
      walk = 32'h1 << i;
      rd("walk", 5'(i), walk, 5'(i - 1), (i == 1) ? 32'h0 : (walk >> 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
